code_lock_param: RTL and testbench

CODE_LOCK_PARAM -- requirements
Module: code_lock_param

---
 rtl/code_lock_pkg.sv | 25 ++
 rtl/lock_timer.sv | 27 ++
 rtl/code_lock_param.sv | 183 ++++++++++++++++++
 tb/tb_code_lock_param.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/code_lock_pkg.sv
// Shared types and default constants for the parameterised code lock.
package code_lock_pkg;

   typedef enum logic [1:0] {
      LOCKED  = 2'd0,
      OPEN    = 2'd1,
      PROG    = 2'd2,
      LOCKOUT = 2'd3
   } state_t;

   localparam int           DEF_SYM_W       = 4;
   localparam int           DEF_CODE_LEN    = 4;
   localparam logic [15:0]  DEF_CODE        = 16'h1101;
   localparam int           DEF_MAX_FAIL    = 3;
   localparam int           DEF_OPEN_CYC    = 8;
   localparam int           DEF_LOCKOUT_CYC = 16;
   localparam int           DEF_ENTRY_TO    = 32;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
module lock_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         done
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - W'(1);
      end
   end

   assign done = (count_reg == '0);

endmodule

// File: rtl/code_lock_param.sv
// Keypad code lock with lockout after repeated failures and in-place reprogramming.
module code_lock_param
   import code_lock_pkg::*;
#(
   parameter int SYM_W       = DEF_SYM_W,
   parameter int CODE_LEN    = DEF_CODE_LEN,
   parameter logic [SYM_W*CODE_LEN-1:0] DEFAULT_CODE = DEF_CODE,
   parameter int MAX_FAIL    = DEF_MAX_FAIL,
   parameter int OPEN_CYC    = DEF_OPEN_CYC,
   parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC,
   parameter int ENTRY_TO    = DEF_ENTRY_TO
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          key_valid,
   input  logic [SYM_W-1:0]              key_sym,
   input  logic                          key_clr,
   input  logic                          prog_en,
   output logic                          unlocked,
   output logic                          alarm,
   output logic                          prog_done,
   output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

   localparam int FW    = $clog2(MAX_FAIL+1);
   localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
   localparam int TW    = $clog2(max3(OPEN_CYC, LOCKOUT_CYC, ENTRY_TO) + 1);
   localparam int CW    = SYM_W*CODE_LEN;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN-1);
   localparam logic [FW-1:0]    FAIL_MAX = FW'(MAX_FAIL);
   // Timers are loaded with N-1 so that the state lasts exactly N cycles.
   localparam logic [TW-1:0]    OPEN_V   = TW'(OPEN_CYC-1);
   localparam logic [TW-1:0]    LOCK_V   = TW'(LOCKOUT_CYC-1);
   localparam logic [TW-1:0]    ENTRY_V  = TW'(ENTRY_TO-1);

   state_t              state_reg;
   logic [IDX_W-1:0]    idx_reg;
   logic                match_reg;
   logic [CW-1:0]       code_reg;
   logic [CW-1:0]       shadow_reg;
   logic [CW-1:0]       shadow_next;
   logic [CODE_LEN-1:0] sym_match;
   logic                sym_hit;
   logic                is_last;
   logic                code_ok;
   logic [FW-1:0]       fail_sat;
   logic                tmr_load;
   logic                tmr_dec;
   logic [TW-1:0]       tmr_val;
   logic                tmr_done;

   for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_sym
      assign sym_match[gi] = (code_reg[gi*SYM_W +: SYM_W] == key_sym);
      assign shadow_next[gi*SYM_W +: SYM_W] =
         (idx_reg == IDX_W'(gi)) ? key_sym : shadow_reg[gi*SYM_W +: SYM_W];
   end

   assign sym_hit  = sym_match[idx_reg];
   assign is_last  = (idx_reg == LAST_IDX);
   assign code_ok  = match_reg && sym_hit;
   assign fail_sat = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + FW'(1);

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      tmr_dec  = 1'b1;
      case (state_reg)
         LOCKED: begin
            if (!key_clr && key_valid) begin
               tmr_load = 1'b1;
               if (is_last && code_ok)
                  tmr_val = OPEN_V;
               else if (is_last && (fail_sat == FAIL_MAX))
                  tmr_val = LOCK_V;
               else
                  tmr_val = ENTRY_V;
            end
         end
         PROG: begin
            if (prog_en && !key_clr && key_valid) begin
               tmr_load = 1'b1;
               tmr_val  = ENTRY_V;
            end
         end
         default: ;
      endcase
   end

   lock_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .done     (tmr_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= LOCKED;
         idx_reg    <= '0;
         match_reg  <= 1'b1;
         code_reg   <= DEFAULT_CODE;
         shadow_reg <= '0;
         fail_cnt   <= '0;
         unlocked   <= 1'b0;
         alarm      <= 1'b0;
         prog_done  <= 1'b0;
      end else begin
         prog_done <= 1'b0;
         case (state_reg)
            LOCKED: begin
               if (key_clr) begin
                  idx_reg   <= '0;
                  match_reg <= 1'b1;
               end else if (key_valid) begin
                  if (is_last) begin
                     idx_reg   <= '0;
                     match_reg <= 1'b1;
                     if (code_ok) begin
                        state_reg <= OPEN;
                        unlocked  <= 1'b1;
                        fail_cnt  <= '0;
                     end else begin
                        fail_cnt <= fail_sat;
                        if (fail_sat == FAIL_MAX) begin
                           state_reg <= LOCKOUT;
                           alarm     <= 1'b1;
                        end
                     end
                  end else begin
                     idx_reg   <= idx_reg + IDX_W'(1);
                     match_reg <= code_ok;
                  end
               end else if ((idx_reg != '0) && tmr_done) begin
                  idx_reg   <= '0;
                  match_reg <= 1'b1;
               end
            end
            OPEN: begin
               if (prog_en) begin
                  state_reg <= PROG;
                  idx_reg   <= '0;
               end else if (tmr_done) begin
                  state_reg <= LOCKED;
                  unlocked  <= 1'b0;
               end
            end
            PROG: begin
               // Dropping prog_en or timing out leaves the stored code untouched.
               if (!prog_en || ((idx_reg != '0) && !key_valid && !key_clr && tmr_done)) begin
                  state_reg <= LOCKED;
                  unlocked  <= 1'b0;
                  idx_reg   <= '0;
               end else if (key_clr) begin
                  idx_reg <= '0;
               end else if (key_valid) begin
                  shadow_reg <= shadow_next;
                  if (is_last) begin
                     code_reg  <= shadow_next;
                     prog_done <= 1'b1;
                     state_reg <= LOCKED;
                     unlocked  <= 1'b0;
                     idx_reg   <= '0;
                  end else begin
                     idx_reg <= idx_reg + IDX_W'(1);
                  end
               end
            end
            LOCKOUT: begin
               if (tmr_done) begin
                  state_reg <= LOCKED;
                  alarm     <= 1'b0;
                  fail_cnt  <= '0;
               end
            end
            default: state_reg <= LOCKED;
         endcase
      end
   end

endmodule

// File: tb/tb_code_lock_param.sv
// Directed scenarios for the code lock with hand-derived expected outputs.
module tb_code_lock_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_valid = 1'b0;
   logic [3:0] key_sym = 4'd0;
   logic       key_clr = 1'b0;
   logic       prog_en = 1'b0;
   logic       unlocked;
   logic       alarm;
   logic       prog_done;
   logic [1:0] fail_cnt;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   code_lock_param dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_sym   (key_sym),
      .key_clr   (key_clr),
      .prog_en   (prog_en),
      .unlocked  (unlocked),
      .alarm     (alarm),
      .prog_done (prog_done),
      .fail_cnt  (fail_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] sym);
      key_sym   = sym;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
   endtask

   // Symbol 0 sits in the low nibble and is entered first.
   task automatic enter(input logic [15:0] code);
      logic [15:0] c;
      c = code;
      for (int i = 0; i < 4; i++) press(c[i*4 +: 4]);
   endtask

   task automatic wait_open(input string tag);
      for (int i = 0; i < 7; i++) begin
         tick();
         check({tag, "_hold"}, 32'(unlocked), 1);
      end
      tick();
      check({tag, "_close"}, 32'(unlocked), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tick();
      tick();
      rst = 1'b0;
      check("rst_unlocked", 32'(unlocked), 0);
      check("rst_alarm", 32'(alarm), 0);
      check("rst_prog_done", 32'(prog_done), 0);
      check("rst_fail_cnt", 32'(fail_cnt), 0);

      // Correct default code opens for exactly 8 cycles.
      enter(16'h1101);
      check("ok_unlocked", 32'(unlocked), 1);
      check("ok_fail_cnt", 32'(fail_cnt), 0);
      wait_open("ok");
      check("ok_fail_after", 32'(fail_cnt), 0);

      // Three wrong codes, then 16 cycles of lockout that ignore the right code.
      enter(16'h0011);
      check("lk_fail1", 32'(fail_cnt), 1);
      enter(16'h0011);
      check("lk_fail2", 32'(fail_cnt), 2);
      enter(16'h0011);
      check("lk_fail3", 32'(fail_cnt), 3);
      check("lk_alarm_on", 32'(alarm), 1);
      enter(16'h1101);
      check("lk_ignored", 32'(unlocked), 0);
      for (int i = 0; i < 11; i++) tick();
      check("lk_alarm_last", 32'(alarm), 1);
      tick();
      check("lk_alarm_off", 32'(alarm), 0);
      check("lk_fail_clr", 32'(fail_cnt), 0);
      enter(16'h1101);
      check("lk_reopen", 32'(unlocked), 1);
      wait_open("lk");

      // key_clr wins over a simultaneous key and restarts the entry.
      press(4'd1);
      press(4'd0);
      key_clr   = 1'b1;
      key_sym   = 4'd1;
      key_valid = 1'b1;
      tick();
      key_clr   = 1'b0;
      key_valid = 1'b0;
      check("clr_fail", 32'(fail_cnt), 0);
      enter(16'h1101);
      check("clr_unlocked", 32'(unlocked), 1);
      wait_open("clr");

      // 31 idle cycles keep a partial entry alive.
      enter(16'h2222);
      check("to_fail_pre", 32'(fail_cnt), 1);
      press(4'd1);
      for (int i = 0; i < 31; i++) tick();
      press(4'd0);
      press(4'd1);
      press(4'd1);
      check("to31_unlocked", 32'(unlocked), 1);
      check("to31_fail", 32'(fail_cnt), 0);
      wait_open("to31");

      // 32 idle cycles discard it without counting a failure.
      enter(16'h2222);
      press(4'd1);
      for (int i = 0; i < 32; i++) tick();
      check("to32_fail", 32'(fail_cnt), 1);
      enter(16'h1101);
      check("to32_unlocked", 32'(unlocked), 1);
      wait_open("to32");

      // Reprogram to 7,3,7,3.
      enter(16'h1101);
      prog_en = 1'b1;
      tick();
      check("pg_hold_open", 32'(unlocked), 1);
      press(4'd7);
      press(4'd3);
      press(4'd7);
      check("pg_no_done", 32'(prog_done), 0);
      check("pg_still_open", 32'(unlocked), 1);
      press(4'd3);
      prog_en = 1'b0;
      check("pg_done", 32'(prog_done), 1);
      check("pg_locked", 32'(unlocked), 0);
      tick();
      check("pg_done_pulse", 32'(prog_done), 0);
      enter(16'h1101);
      check("pg_old_code", 32'(unlocked), 0);
      check("pg_old_fail", 32'(fail_cnt), 1);
      enter(16'h3737);
      check("pg_new_code", 32'(unlocked), 1);
      check("pg_new_fail", 32'(fail_cnt), 0);
      wait_open("pg");

      // Reset in the middle of programming restores the default code.
      enter(16'h3737);
      prog_en = 1'b1;
      tick();
      press(4'd5);
      press(4'd5);
      check("mr_pre_open", 32'(unlocked), 1);
      #2;
      rst = 1'b1;
      #1;
      check("mr_unlocked", 32'(unlocked), 0);
      check("mr_prog_done", 32'(prog_done), 0);
      key_sym   = 4'd5;
      key_valid = 1'b1;
      tick();
      tick();
      key_valid = 1'b0;
      prog_en   = 1'b0;
      rst       = 1'b0;
      check("mr_fail", 32'(fail_cnt), 0);
      enter(16'h1101);
      check("mr_default_code", 32'(unlocked), 1);
      wait_open("mr");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
